// File: rtl/fetch_queue_if.sv
// fetch_queue_if: PC, instruction-memory and decode-side signals of the fetch stage.
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pc_adv;
    logic [ADDR_W-1:0] pc_in;
    logic              redirect;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              busy;

    modport master (
        input  pc_in, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output pc_adv, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, busy
    );

    modport slave (
        output pc_in, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  pc_adv, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, busy
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: issues one imem read per PC, buffers PC-tagged instructions in a FIFO for decode.
module fetch_queue #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2;

    logic [1:0]        state, state_next;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] pending_pc;
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic              fire, push, pop;

    // At most one request in flight, so count cannot grow past DEPTH.
    assign bus.imem_req_valid = !reset && state == IDLE && count < FULL && !bus.redirect;
    assign bus.imem_req_addr  = {bus.pc_in[ADDR_W-1:2], 2'b00};
    assign fire               = bus.imem_req_valid && bus.imem_req_ready;
    assign bus.pc_adv         = fire;
    assign bus.busy           = state != IDLE;
    assign bus.id_valid       = count != '0;
    assign bus.id_instr       = instr_q[rd_ptr];
    assign bus.id_pc          = pc_q[rd_ptr];
    assign push               = state == WAIT && bus.imem_rsp_valid && !bus.redirect;
    assign pop                = bus.id_valid && bus.id_ready && !bus.redirect;

    always_comb begin
        state_next = state == IDLE ? (fire ? WAIT : IDLE) :
                     state == WAIT ? (bus.imem_rsp_valid ? IDLE : bus.redirect ? DISCARD : WAIT) :
                     (bus.imem_rsp_valid ? IDLE : DISCARD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state <= state_next;
            if (fire)
                pending_pc <= bus.pc_in;
            if (push) begin
                instr_q[wr_ptr] <= bus.imem_rsp_data;
                pc_q[wr_ptr]    <= pending_pc;
            end
            // A redirect flushes everything; a same-cycle pop is dropped.
            if (bus.redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push);
                rd_ptr <= rd_ptr + PW'(pop);
                count  <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a PC-register and 1-cycle memory model.
module tb_fetch_queue;
    logic clk = 0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic auto_rsp;
    logic [31:0] target;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fetch_queue #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return a == 32'h0 ? 32'h20080005 : (32'h10000000 | a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: the PC register and (optionally) the memory react to the edge.
    task automatic tick();
        logic fire, adv, redir;
        logic [31:0] addr;
        fire  = bus.imem_req_valid && bus.imem_req_ready;
        addr  = bus.imem_req_addr;
        adv   = bus.pc_adv;
        redir = bus.redirect;
        @(posedge clk);
        #1;
        if (redir)
            bus.pc_in = target;
        else if (adv)
            bus.pc_in = bus.pc_in + 32'd4;
        if (auto_rsp) begin
            bus.imem_rsp_valid = fire;
            bus.imem_rsp_data  = fire ? mem_of(addr) : 32'h0;
        end
        #1;
    endtask

    initial begin
        reset = 1;
        auto_rsp = 1;
        target = 0;
        bus.pc_in = 0;
        bus.redirect = 0;
        bus.imem_req_ready = 1;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        bus.id_ready = 0;
        tick();
        tick();
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_pc_adv", bus.pc_adv, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_instr", bus.id_instr, 0);
        chk("rst_id_pc", bus.id_pc, 0);

        reset = 0;
        #1;
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_pc_adv", bus.pc_adv, 1);
        chk("first_addr", bus.imem_req_addr, 32'h0);
        tick();
        chk("wait_busy", bus.busy, 1);
        chk("wait_req_valid", bus.imem_req_valid, 0);
        chk("wait_id_valid", bus.id_valid, 0);
        tick();
        chk("first_id_valid", bus.id_valid, 1);
        chk("first_id_pc", bus.id_pc, 32'h0);
        chk("first_id_instr", bus.id_instr, 32'h20080005);
        chk("first_busy", bus.busy, 0);
        chk("second_addr", bus.imem_req_addr, 32'h4);

        // Streaming: one instruction every two cycles.
        bus.id_ready = 1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk("stream_gap", bus.id_valid, 0);
            tick();
            chk("stream_valid", bus.id_valid, 1);
            chk("stream_pc", bus.id_pc, 32'(4 * k));
            chk("stream_instr", bus.id_instr, 32'h10000000 | 32'(4 * k));
        end

        // Backpressure fills the 2-entry FIFO and stalls fetch.
        bus.id_ready = 0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("full_req_valid", bus.imem_req_valid, 0);
            chk("full_id_pc", bus.id_pc, 32'h8);
            tick();
        end
        chk("full_pc_in", bus.pc_in, 32'h10);
        bus.id_ready = 1;
        #1;
        chk("full_before_pop", bus.imem_req_valid, 0);
        tick();
        chk("drain_pc1", bus.id_pc, 32'hC);
        chk("resume_req", bus.imem_req_valid, 1);
        chk("resume_addr", bus.imem_req_addr, 32'h10);
        tick();
        chk("drain_empty", bus.id_valid, 0);
        tick();
        chk("drain_pc2", bus.id_pc, 32'h10);

        // Redirect while a request is outstanding; late response must be dropped.
        auto_rsp = 0;
        tick();
        chk("redir_busy", bus.busy, 1);
        target = 32'h40;
        bus.redirect = 1;
        #1;
        chk("redir_no_adv", bus.pc_adv, 0);
        chk("redir_no_req", bus.imem_req_valid, 0);
        tick();
        bus.redirect = 0;
        #1;
        chk("discard_busy", bus.busy, 1);
        chk("discard_id_valid", bus.id_valid, 0);
        chk("discard_no_req", bus.imem_req_valid, 0);
        tick();
        tick();
        bus.imem_rsp_valid = 1;
        bus.imem_rsp_data = 32'hDEADBEEF;
        #1;
        chk("discard_still_no_req", bus.imem_req_valid, 0);
        tick();
        bus.imem_rsp_valid = 0;
        #1;
        chk("discard_dropped", bus.id_valid, 0);
        chk("discard_idle", bus.busy, 0);
        chk("target_addr", bus.imem_req_addr, 32'h40);
        auto_rsp = 1;
        tick();
        tick();
        chk("target_id_pc", bus.id_pc, 32'h40);
        chk("target_id_instr", bus.id_instr, 32'h10000040);

        // Redirect coinciding with the response in WAIT.
        tick();
        chk("coinc_rsp", bus.imem_rsp_valid, 1);
        target = 32'h80;
        bus.redirect = 1;
        tick();
        bus.redirect = 0;
        #1;
        chk("coinc_id_valid", bus.id_valid, 0);
        chk("coinc_idle", bus.busy, 0);
        chk("coinc_addr", bus.imem_req_addr, 32'h80);

        // Redirect with a full FIFO and a simultaneous pop.
        bus.id_ready = 0;
        tick();
        tick();
        tick();
        tick();
        chk("full2_no_req", bus.imem_req_valid, 0);
        chk("full2_id_pc", bus.id_pc, 32'h80);
        bus.id_ready = 1;
        target = 32'h100;
        bus.redirect = 1;
        tick();
        bus.redirect = 0;
        #1;
        chk("flush_id_valid", bus.id_valid, 0);
        chk("flush_idle", bus.busy, 0);
        chk("flush_addr", bus.imem_req_addr, 32'h100);
        tick();
        chk("flush_busy", bus.busy, 1);

        // Reset while busy, then a stale response.
        auto_rsp = 0;
        bus.imem_rsp_valid = 0;
        reset = 1;
        bus.pc_in = 32'h200;
        #1;
        chk("rst2_req_valid", bus.imem_req_valid, 0);
        tick();
        chk("rst2_busy", bus.busy, 0);
        chk("rst2_id_valid", bus.id_valid, 0);
        chk("rst2_id_instr", bus.id_instr, 0);
        chk("rst2_id_pc", bus.id_pc, 0);
        reset = 0;
        bus.id_ready = 0;
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 1;
        bus.imem_rsp_data = 32'hBAD0BAD0;
        tick();
        bus.imem_rsp_valid = 0;
        #1;
        chk("stale_busy", bus.busy, 0);
        chk("stale_id_valid", bus.id_valid, 0);
        bus.imem_req_ready = 1;
        #1;
        chk("post_rst_addr", bus.imem_req_addr, 32'h200);
        chk("post_rst_adv", bus.pc_adv, 1);
        auto_rsp = 1;
        tick();
        tick();
        chk("post_rst_id_pc", bus.id_pc, 32'h200);
        chk("post_rst_id_instr", bus.id_instr, 32'h10000200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
